// File: rtl/pu_wr_packer_pkg.sv
// -----------------------------------------------------------------------------
// pu_wr_packer_pkg
//   Shared helpers for the PU write packer: width arithmetic used to size the
//   lane counter, input word and FIFO occupancy count, plus the packer FSM
//   state encoding.
// -----------------------------------------------------------------------------
package pu_wr_packer_pkg;

  // Ceiling log2; C_LOG_2(1) = 0.
  function automatic int C_LOG_2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to count lanes 0..ratio-1 within one output beat.
  function automatic int PACK_LANE_W(input int ratio);
    return C_LOG_2(ratio);
  endfunction

  // Width of one PU output word.
  function automatic int PU_IN_W(input int op, input int pe);
    return op * pe;
  endfunction

  // PK_RESET : first cycle(s) after reset, input still blocked
  // PK_RUN   : packing PU words
  // PK_FLUSH : flush pending, input blocked until it is serviced
  typedef enum logic [1:0] {
    PK_RESET = 2'd0,
    PK_RUN   = 2'd1,
    PK_FLUSH = 2'd2
  } pk_state_e;

endpackage

// File: rtl/pu_wr_packer_if.sv
// -----------------------------------------------------------------------------
// pu_wr_packer_if
//   Bundles the PU write stream, the flush handshake and the memory-controller
//   write stream of the packer.
//   slave  : the packer (consumes PU words and flush, produces beats)
//   master : the surrounding logic (PU mux, sequencer, memory controller)
// -----------------------------------------------------------------------------
interface pu_wr_packer_if
  import pu_wr_packer_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int OUT_WIDTH  = 256,
  parameter int FIFO_DEPTH = 8
);
  localparam int IN_W  = PU_IN_W(OP_WIDTH, NUM_PE);
  localparam int CNT_W = C_LOG_2(FIFO_DEPTH) + 1;

  logic                 pu_write_req;
  logic [IN_W-1:0]      pu_write_data;
  logic                 pu_write_ready;
  logic                 flush;
  logic                 flush_done;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;
  logic [CNT_W-1:0]     out_count;

  modport slave (
    input  pu_write_req, pu_write_data, flush, out_ready,
    output pu_write_ready, flush_done, out_valid, out_data, out_last, out_count
  );

  modport master (
    output pu_write_req, pu_write_data, flush, out_ready,
    input  pu_write_ready, flush_done, out_valid, out_data, out_last, out_count
  );

endinterface

// File: rtl/pu_wr_packer_fifo_fwft.sv
// -----------------------------------------------------------------------------
// pu_wr_packer_fifo_fwft
//   First-word-fall-through FIFO holding packed output beats.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write din at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry, forced to zero while empty
//   full/empty : derived from the registered occupancy count
//   count      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pu_wr_packer_fifo_fwft
  import pu_wr_packer_pkg::*;
#(
  parameter int WIDTH = 257,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [C_LOG_2(DEPTH):0]    count
);
  localparam int AW = C_LOG_2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Zero while empty so the head is clean during and right after reset.
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pu_wr_packer.sv
// -----------------------------------------------------------------------------
// pu_wr_packer
//   Packs RATIO = OUT_WIDTH/IN_W consecutive PU words (little-endian lanes)
//   into memory-write beats and buffers them in a FWFT FIFO. A flush pulse
//   closes a partial beat (upper lanes zero, last flag set).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pu_wr_packer_if.slave
//     pu_write_req/data/ready : PU word stream in
//     flush / flush_done      : close partial beat / serviced pulse
//     out_valid/data/last/ready, out_count : beat stream out, FIFO occupancy
// -----------------------------------------------------------------------------
module pu_wr_packer
  import pu_wr_packer_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int OUT_WIDTH  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  pu_wr_packer_if.slave  bus
);
  localparam int IN_W   = PU_IN_W(OP_WIDTH, NUM_PE);
  localparam int RATIO  = OUT_WIDTH / IN_W;
  localparam int LANE_W = PACK_LANE_W(RATIO);
  localparam int CNT_W  = C_LOG_2(FIFO_DEPTH) + 1;
  localparam int FW     = OUT_WIDTH + 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

  pk_state_e             state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [OUT_WIDTH-1:0]  asm_q, asm_d;

  logic                  ready, accept, flush_take, service;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_din, fifo_dout;
  logic [CNT_W-1:0]      fifo_count;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    fifo_push = 1'b0;
    fifo_din  = '0;

    // Registered full only, so a push never meets a full FIFO.
    ready      = (state_q == PK_RUN) && !fifo_full;
    accept     = bus.pu_write_req && ready;
    // A flush while one is already pending merges into it.
    flush_take = bus.flush && (state_q != PK_FLUSH);
    service    = (state_q == PK_FLUSH) && !fifo_full;

    case (state_q)
      PK_RESET: state_d = flush_take ? PK_FLUSH : PK_RUN;
      PK_RUN:   if (flush_take) state_d = PK_FLUSH;
      PK_FLUSH: if (service) state_d = PK_RUN;
      default:  state_d = PK_RESET;
    endcase

    if (accept) begin
      if (lane_q == LANE_MAX) begin
        // Top lane goes straight to the FIFO; a coincident flush marks it last.
        fifo_push = 1'b1;
        fifo_din  = {flush_take, bus.pu_write_data, asm_q[OUT_WIDTH-IN_W-1:0]};
        lane_d    = '0;
        asm_d     = '0;
      end else begin
        for (int k = 0; k < RATIO; k++) begin
          if (lane_q == LANE_W'(k)) asm_d[k*IN_W +: IN_W] = bus.pu_write_data;
        end
        lane_d = lane_q + LANE_W'(1);
      end
    end

    // Unwritten lanes are already zero because the assembly clears on push.
    if (service) begin
      if (lane_q != '0) begin
        fifo_push = 1'b1;
        fifo_din  = {1'b1, asm_q};
      end
      lane_d = '0;
      asm_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PK_RESET;
      lane_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
    end
  end

  assign fifo_pop = !fifo_empty && bus.out_ready;

  pu_wr_packer_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.pu_write_ready = ready;
  assign bus.flush_done     = service;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_dout[OUT_WIDTH-1:0];
  assign bus.out_last       = fifo_dout[OUT_WIDTH];
  assign bus.out_count      = fifo_count;

endmodule
